fft_frame_sequencer: RTL and testbench

Single-clock controller that sits between the read side of the audio sample FIFO and the FFT core's streaming sink. It waits until a full frame of NSamples is buffered, then drains exactly NSamples words into the FFT with sop/eop framing and full ready/valid backpressure, and counts completed frames. It is the only block that drives the FIFO `rdreq` on the `clk` side.

---
 rtl/fft_seq_pkg.sv | 18 +
 rtl/fft_seq_skid.sv | 47 ++++
 rtl/fft_frame_sequencer.sv | 136 +++++++++++++
 tb/tb_fft_frame_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_seq_pkg
// Description : Shared types for the FFT frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        STREAM = 2'd2
    } seq_state_t;

    localparam int FRAME_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/fft_seq_skid.sv
`default_nettype none
// ============================================================================
// Module      : fft_seq_skid
// Description : Two-entry output buffer between FIFO read data and FFT sink.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_seq_skid #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_occ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign occ  = r_occ;
    assign head = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_sequencer
// Description : Drains full NSamples frames from the sample FIFO into the FFT
//               sink with sop/eop framing and ready/valid backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int W        = 16,
    parameter int NSamples = 32,
    parameter int DEPTH    = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [$clog2(DEPTH):0]      fifo_rdusedw,
    output logic                        fifo_rdreq,
    input  logic signed [W-1:0]         fifo_q,
    input  logic                        fft_sink_ready,
    output logic                        fft_sink_valid,
    output logic                        fft_sink_sop,
    output logic                        fft_sink_eop,
    output logic signed [W-1:0]         fft_sink_real,
    output logic signed [W-1:0]         fft_sink_imag,
    output logic                        busy,
    output logic [FRAME_CNT_W-1:0]      frame_count
);

    localparam int c_cnt_w  = $clog2(NSamples);
    localparam int c_used_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w:0]    c_issue_max = (c_cnt_w + 1)'(NSamples);
    localparam logic [c_cnt_w-1:0]  c_last_beat = c_cnt_w'(NSamples - 1);
    localparam logic [c_used_w-1:0] c_fill      = c_used_w'(NSamples);

    seq_state_t               r_state;
    seq_state_t               w_state_next;
    logic [c_cnt_w:0]         r_issue_cnt;
    logic [c_cnt_w-1:0]       r_out_cnt;
    logic                     r_inflight;
    logic [FRAME_CNT_W-1:0]   r_frame_count;

    logic [1:0]               w_occ;
    logic [W-1:0]             w_head;
    logic                     w_pop;
    logic                     w_eop_acc;
    logic [2:0]               w_level;

    fft_seq_skid #(
        .W (W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (r_inflight),
        .push_data (fifo_q),
        .pop       (w_pop),
        .occ       (w_occ),
        .head      (w_head)
    );

    assign fft_sink_valid = (w_occ != 2'd0);
    assign w_pop          = fft_sink_valid & fft_sink_ready;
    assign w_eop_acc      = w_pop && (r_out_cnt == c_last_beat);

    // Words buffered plus the one in flight, after this cycle's pop; a new
    // read is only allowed if it still fits in the two-entry buffer.
    assign w_level    = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_rdreq = (r_state == STREAM) && (r_issue_cnt < c_issue_max) &&
                        (fifo_rdusedw != '0) && (w_level < 3'd2);

    assign fft_sink_sop  = fft_sink_valid && (r_out_cnt == '0);
    assign fft_sink_eop  = fft_sink_valid && (r_out_cnt == c_last_beat);
    assign fft_sink_real = signed'(w_head);
    assign fft_sink_imag = '0;
    assign busy          = (r_state != IDLE);
    assign frame_count   = r_frame_count;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_next = ARM;
                end
            end
            ARM: begin
                if (!enable) begin
                    w_state_next = IDLE;
                end else if (fifo_rdusedw >= c_fill) begin
                    w_state_next = STREAM;
                end
            end
            STREAM: begin
                // enable is only consulted once the whole frame has gone out
                if (w_eop_acc) begin
                    w_state_next = enable ? ARM : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issue_cnt   <= '0;
            r_out_cnt     <= '0;
            r_inflight    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_inflight <= fifo_rdreq;
            if (w_eop_acc) begin
                r_issue_cnt   <= '0;
                r_out_cnt     <= '0;
                r_frame_count <= r_frame_count + 1'b1;
            end else begin
                if (fifo_rdreq) begin
                    r_issue_cnt <= r_issue_cnt + 1'b1;
                end
                if (w_pop) begin
                    r_out_cnt <= r_out_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_frame_sequencer
// Description : Self-checking bench with a FIFO model and an output scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_sequencer;

    localparam int W  = 16;
    localparam int N  = 32;
    localparam int DP = 64;
    localparam int UW = 7;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 enable = 1'b0;
    logic                 ready = 1'b0;
    logic [UW-1:0]        fifo_rdusedw = '0;
    logic signed [W-1:0]  fifo_q = '0;
    logic                 fifo_rdreq;
    logic                 valid, sop, eop, busy;
    logic signed [W-1:0]  sreal, simag;
    logic [15:0]          frame_count;

    always #5 clk = ~clk;

    fft_frame_sequencer #(
        .W        (W),
        .NSamples (N),
        .DEPTH    (DP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .fifo_rdusedw   (fifo_rdusedw),
        .fifo_rdreq     (fifo_rdreq),
        .fifo_q         (fifo_q),
        .fft_sink_ready (ready),
        .fft_sink_valid (valid),
        .fft_sink_sop   (sop),
        .fft_sink_eop   (eop),
        .fft_sink_real  (sreal),
        .fft_sink_imag  (simag),
        .busy           (busy),
        .frame_count    (frame_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    // FIFO contents, words read but not yet accepted, and accepted-beat log
    logic [W-1:0] fq[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] acc_log[$];
    bit           sop_log[$];
    bit           eop_log[$];
    int           beat_idx = 0;
    int           model_fc = 0;
    int           acc_cnt = 0;
    int           rd_cnt = 0;
    int           cyc = 0;
    int           first_rd_cyc = -1;
    int           first_val_cyc = -1;
    int           last_acc_cyc = -1;
    bit           cap_rd = 1'b0;
    bit           prev_valid = 1'b0;
    bit           prev_ready = 1'b0;
    logic [W-1:0] prev_real = '0;
    int           wval = 1;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            exp_q.delete();
            beat_idx   = 0;
            model_fc   = 0;
            cap_rd     = 1'b0;
            prev_valid = 1'b0;
            check("rst_valid", {31'd0, valid}, 0);
            check("rst_rdreq", {31'd0, fifo_rdreq}, 0);
            check("rst_sop_eop", {30'd0, sop, eop}, 0);
            check("rst_busy", {31'd0, busy}, 0);
            check("rst_real", {16'd0, sreal}, 0);
            check("rst_frame_count", {16'd0, frame_count}, 0);
        end else begin
            cap_rd = fifo_rdreq;
            if (fifo_rdreq) begin
                rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                check("rdreq_only_busy", {31'd0, busy}, 1);
            end
            if (valid && first_val_cyc < 0) first_val_cyc = cyc;
            check("frame_count", {16'd0, frame_count}, model_fc);
            check("imag_zero", {16'd0, simag}, 0);
            if (prev_valid && !prev_ready) begin
                check("hold_valid", {31'd0, valid}, 1);
                check("hold_data", {16'd0, sreal}, {16'd0, prev_real});
            end
            check("sop", {31'd0, sop}, {31'd0, valid && beat_idx == 0});
            check("eop", {31'd0, eop}, {31'd0, valid && beat_idx == N - 1});
            check("readahead_le2",
                  {31'd0, (exp_q.size() - int'(valid && ready) + int'(fifo_rdreq)) <= 2}, 1);
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("beat_without_read", 1, 0);
                end else begin
                    check("beat_data", {16'd0, sreal}, {16'd0, exp_q.pop_front()});
                end
                acc_log.push_back(sreal);
                sop_log.push_back(sop);
                eop_log.push_back(eop);
                acc_cnt++;
                last_acc_cyc = cyc;
                if (beat_idx == N - 1) begin
                    beat_idx = 0;
                    model_fc = (model_fc + 1) & 16'hFFFF;
                end else begin
                    beat_idx++;
                end
            end
            prev_valid = valid;
            prev_ready = ready;
            prev_real  = sreal;
        end
    end

    // FIFO read side: data appears on fifo_q the cycle after rdreq
    always @(posedge clk) begin
        #1;
        if (cap_rd) begin
            check("read_nonempty", {31'd0, fq.size() != 0}, 1);
            if (fq.size() != 0) begin
                fifo_q = fq.pop_front();
                exp_q.push_back(fifo_q);
            end
        end
        fifo_rdusedw = UW'(fq.size());
    end

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(W'(wval));
            wval++;
        end
        fifo_rdusedw = UW'(fq.size());
    endtask

    task automatic wait_acc(input int target, input int budget, input string name);
        int n = 0;
        while (acc_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, {31'd0, acc_cnt >= target}, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, rbase, idx, bad, seen, pushed;

        // Reset / idle with 40 words present and enable low
        wval = 1000;
        push_words(40);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_rdreq || valid || busy) bad++;
        end
        check("idle_quiet", bad, 0);
        check("idle_frame_count", {16'd0, frame_count}, 0);
        @(posedge clk);
        #1;
        fq.delete();
        fifo_rdusedw = '0;

        // Single frame of ramp 1..32
        wval = 1;
        push_words(32);
        base = acc_cnt; rbase = rd_cnt; idx = acc_log.size();
        first_rd_cyc = -1; first_val_cyc = -1;
        enable = 1'b1; ready = 1'b1;
        wait_acc(base + N, 200, "single_done");
        repeat (5) @(posedge clk);
        #1;
        check("single_rdreqs", rd_cnt - rbase, N);
        check("single_first_val", {16'd0, acc_log[idx]}, 1);
        check("single_first_sop", {31'd0, sop_log[idx]}, 1);
        check("single_last_val", {16'd0, acc_log[idx + N - 1]}, 32);
        check("single_last_eop", {31'd0, eop_log[idx + N - 1]}, 1);
        check("single_valid_latency", first_val_cyc - first_rd_cyc, 2);
        check("single_frame_span", last_acc_cyc - first_rd_cyc, N + 1);
        check("single_frame_count", {16'd0, frame_count}, 1);
        check("single_back_to_arm", {31'd0, busy}, 1);

        // Fill gate: 31 words must not start a frame, the 32nd must
        push_words(31);
        rbase = rd_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("gate_no_rdreq_31", rd_cnt - rbase, 0);
        push_words(1);
        seen = 0;
        for (int i = 1; i <= 4 && seen == 0; i++) begin
            @(negedge clk);
            if (fifo_rdreq) seen = i;
        end
        check("gate_rdreq_within_2", {31'd0, seen >= 1 && seen <= 2}, 1);
        wait_acc(base + 2 * N, 200, "gate_frame_done");
        check("gate_frame_count", {16'd0, frame_count}, 2);

        // Backpressure over three frames
        base = acc_cnt;
        pushed = 0;
        push_words(64);
        for (int i = 0; i < 2000 && acc_cnt < base + 3 * N; i++) begin
            @(posedge clk);
            #1;
            ready = 1'($urandom_range(0, 1));
            if (!pushed && fq.size() < 8) begin
                push_words(32);
                pushed = 1;
            end
        end
        ready = 1'b1;
        check("bp_done", {31'd0, acc_cnt >= base + 3 * N}, 1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_frame_count", {16'd0, frame_count}, 5);
        check("bp_last_val", {16'd0, acc_log[acc_log.size() - 1]}, 160);

        // Disable after beat 10: frame completes, then IDLE, no more reads
        base = acc_cnt;
        push_words(64);
        wait_acc(base + 10, 200, "dis_beat10");
        enable = 1'b0;
        wait_acc(base + N, 200, "dis_frame_done");
        repeat (3) @(posedge clk);
        #1;
        check("dis_idle", {31'd0, busy}, 0);
        check("dis_last_val", {16'd0, acc_log[acc_log.size() - 1]}, 192);
        rbase = rd_cnt;
        repeat (30) @(posedge clk);
        #1;
        check("dis_no_rdreq", rd_cnt - rbase, 0);
        check("dis_frame_count", {16'd0, frame_count}, 6);

        // Reset after beat 15, then a clean frame from sop
        base = acc_cnt;
        enable = 1'b1;
        wait_acc(base + 15, 200, "rst_beat15");
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_valid", {31'd0, valid}, 0);
        check("rstmid_rdreq", {31'd0, fifo_rdreq}, 0);
        check("rstmid_busy", {31'd0, busy}, 0);
        check("rstmid_frame_count", {16'd0, frame_count}, 0);
        repeat (3) @(posedge clk);
        #1;
        push_words(32);
        reset = 1'b1;
        idx = acc_log.size();
        base = acc_cnt;
        wait_acc(base + N, 300, "rstmid_frame_done");
        repeat (2) @(posedge clk);
        #1;
        check("rstmid_restart_sop", {31'd0, sop_log[idx]}, 1);
        check("rstmid_restart_eop", {31'd0, eop_log[idx + N - 1]}, 1);
        check("rstmid_frame_count_after", {16'd0, frame_count}, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
